bubsys_snd_mixer: RTL and testbench

//  Audio mixing stage ahead of AUDIO_L/AUDIO_R. It mixes four sound sources per output sample:
//  K5289, VLM, PSG1 and PSG2. Each source has its own OSD volume trim (signed 4-bit, from i_VOL).
//  It uses one shared multiplier, time-multiplexed: one multiply-accumulate (MAC) per clock.
//  The sum is saturated to signed 16-bit and driven to o_SND_L/o_SND_R (mono, both equal).

---
 rtl/bubsys_snd_mixer_pkg.sv | 32 +++
 rtl/bubsys_snd_mixer_if.sv | 25 ++
 rtl/bubsys_snd_mixer_dcblock.sv | 46 ++++
 rtl/bubsys_snd_mixer.sv | 145 ++++++++++++++
 tb/tb_bubsys_snd_mixer.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/bubsys_snd_mixer_pkg.sv
// Shared types and helpers for the four-source sound mixer.
// Used by bubsys_snd_mixer and by bubsys_snd_dcblock (built only with BUBSYS_SNDMIX_DCBLOCK_EN).
package bubsys_snd_pkg;

  localparam int SMPL_W_DEF = 16;
  localparam int SMPL_MAX   = 32767;
  localparam int SMPL_MIN   = -32768;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAC0,
    ST_MAC1,
    ST_MAC2,
    ST_MAC3,
    ST_SAT
  } mix_state_t;

  typedef enum logic [1:0] {
    CH_K5289,
    CH_VLM,
    CH_PSG1,
    CH_PSG2
  } mix_chan_t;

  // gain = 32 + 4*v. The modulo-128 sum maps v=-8 to 0 and v=+7 to 60.
  function automatic logic [5:0] vol2gain(input logic signed [3:0] v);
    logic [6:0] g;
    g = 7'd32 + {v[3], v, 2'b00};
    return g[5:0];
  endfunction

endpackage

// File: rtl/bubsys_snd_mixer_if.sv
// Sample inputs, volume word and mixed output of the sound mixer.
interface bubsys_snd_mixer_if #(
  parameter int SMPL_W = 16
);
  logic                     i_SMPL_CEN;
  logic signed [SMPL_W-1:0] i_K5289;
  logic signed [SMPL_W-1:0] i_VLM;
  logic signed [SMPL_W-1:0] i_PSG1;
  logic signed [SMPL_W-1:0] i_PSG2;
  logic        [15:0]       i_VOL;
  logic signed [SMPL_W-1:0] o_SND_L;
  logic signed [SMPL_W-1:0] o_SND_R;
  logic                     o_SND_STB;
  logic                     o_OVERRUN;

  modport master (
    output i_SMPL_CEN, i_K5289, i_VLM, i_PSG1, i_PSG2, i_VOL,
    input  o_SND_L, o_SND_R, o_SND_STB, o_OVERRUN
  );

  modport slave (
    input  i_SMPL_CEN, i_K5289, i_VLM, i_PSG1, i_PSG2, i_VOL,
    output o_SND_L, o_SND_R, o_SND_STB, o_OVERRUN
  );
endinterface

// File: rtl/bubsys_snd_mixer_dcblock.sv
// DC-blocking high-pass: y = x - x_prev + y_prev - (y_prev >>> 8), saturated.
// Only instantiated when BUBSYS_SNDMIX_DCBLOCK_EN is defined.
module bubsys_snd_dcblock
  import bubsys_snd_pkg::*;
#(
  parameter int SMPL_W = SMPL_W_DEF
) (
  input  logic                     CLK72M,
  input  logic                     RESET,
  input  logic                     x_vld,
  input  logic signed [SMPL_W-1:0] x,
  output logic                     y_vld,
  output logic signed [SMPL_W-1:0] y
);

  localparam int W = SMPL_W + 3;
  localparam logic signed [W-1:0] Y_HI = W'(SMPL_MAX);
  localparam logic signed [W-1:0] Y_LO = W'(SMPL_MIN);

  logic signed [SMPL_W-1:0] x_prev;
  logic signed [W-1:0]      y_raw;
  logic signed [SMPL_W-1:0] y_sat;

  // y itself is y_prev: the register only changes on x_vld.
  always_comb begin
    y_raw = W'(x) - W'(x_prev) + W'(y) - W'(y >>> 8);
    if (y_raw > Y_HI)      y_sat = SMPL_W'(SMPL_MAX);
    else if (y_raw < Y_LO) y_sat = SMPL_W'(SMPL_MIN);
    else                   y_sat = y_raw[SMPL_W-1:0];
  end

  always_ff @(posedge CLK72M) begin
    if (RESET) begin
      x_prev <= '0;
      y      <= '0;
      y_vld  <= 1'b0;
    end else begin
      y_vld <= x_vld;
      if (x_vld) begin
        x_prev <= x;
        y      <= y_sat;
      end
    end
  end

endmodule

// File: rtl/bubsys_snd_mixer.sv
// Four-source mono mixer with one time-shared multiplier (one MAC per clock).
// Optional DC-blocking stage under BUBSYS_SNDMIX_DCBLOCK_EN.
module bubsys_snd_mixer
  import bubsys_snd_pkg::*;
#(
  parameter int SMPL_W    = SMPL_W_DEF,
  parameter int ACC_W     = 20,
  parameter int GAIN_FRAC = 5
) (
  input  logic               i_EMU_CLK72M,
  input  logic               i_EMU_SOFTRST,
  bubsys_snd_mixer_if.slave  snd
);

  localparam int PW = SMPL_W + 7;
  localparam logic signed [ACC_W-1:0] ACC_HI = ACC_W'(SMPL_MAX);
  localparam logic signed [ACC_W-1:0] ACC_LO = ACC_W'(SMPL_MIN);

  mix_state_t state, state_nx;
  mix_chan_t  chan;

  logic signed [SMPL_W-1:0] smp_q  [4];
  logic        [5:0]        gain_q [4];
  logic signed [ACC_W-1:0]  acc;
  logic signed [SMPL_W-1:0] mac_smp;
  logic        [5:0]        mac_gain;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  term;
  logic signed [SMPL_W-1:0] sat_val;
  logic signed [SMPL_W-1:0] sat_q;
  logic                     sat_vld;
  logic signed [SMPL_W-1:0] res;
  logic                     res_vld;
  logic signed [SMPL_W-1:0] out_q;
  logic                     stb_q;
  logic                     ovr_q;

  always_ff @(posedge i_EMU_CLK72M) begin
    if (i_EMU_SOFTRST) state <= ST_IDLE;
    else               state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (snd.i_SMPL_CEN) state_nx = ST_MAC0;
      ST_MAC0: state_nx = ST_MAC1;
      ST_MAC1: state_nx = ST_MAC2;
      ST_MAC2: state_nx = ST_MAC3;
      ST_MAC3: state_nx = ST_SAT;
      ST_SAT:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    chan = CH_K5289;
    case (state)
      ST_MAC1: chan = CH_VLM;
      ST_MAC2: chan = CH_PSG1;
      ST_MAC3: chan = CH_PSG2;
      default: chan = CH_K5289;
    endcase
  end

  // Gain is unsigned, so zero-extend before the signed multiply.
  always_comb begin
    mac_smp  = smp_q[chan];
    mac_gain = gain_q[chan];
    prod     = PW'(mac_smp) * PW'($signed({1'b0, mac_gain}));
    term     = ACC_W'(prod >>> GAIN_FRAC);
    if (acc > ACC_HI)      sat_val = SMPL_W'(SMPL_MAX);
    else if (acc < ACC_LO) sat_val = SMPL_W'(SMPL_MIN);
    else                   sat_val = acc[SMPL_W-1:0];
  end

  always_ff @(posedge i_EMU_CLK72M) begin
    if (i_EMU_SOFTRST) begin
      for (int unsigned i = 0; i < 4; i++) begin
        smp_q[i]  <= '0;
        gain_q[i] <= '0;
      end
      acc     <= '0;
      sat_q   <= '0;
      sat_vld <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sat_vld <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (snd.i_SMPL_CEN) begin
            smp_q[CH_K5289]  <= snd.i_K5289;
            smp_q[CH_VLM]    <= snd.i_VLM;
            smp_q[CH_PSG1]   <= snd.i_PSG1;
            smp_q[CH_PSG2]   <= snd.i_PSG2;
            gain_q[CH_K5289] <= vol2gain(snd.i_VOL[3:0]);
            gain_q[CH_VLM]   <= vol2gain(snd.i_VOL[7:4]);
            gain_q[CH_PSG1]  <= vol2gain(snd.i_VOL[11:8]);
            gain_q[CH_PSG2]  <= vol2gain(snd.i_VOL[15:12]);
            acc              <= '0;
          end
        end
        ST_MAC0, ST_MAC1, ST_MAC2, ST_MAC3: acc <= acc + term;
        ST_SAT: begin
          sat_q   <= sat_val;
          sat_vld <= 1'b1;
        end
        default: ;
      endcase
      if (state != ST_IDLE && snd.i_SMPL_CEN) ovr_q <= 1'b1;
    end
  end

`ifdef BUBSYS_SNDMIX_DCBLOCK_EN
  bubsys_snd_dcblock #(
    .SMPL_W (SMPL_W)
  ) u_dcblock (
    .CLK72M (i_EMU_CLK72M),
    .RESET  (i_EMU_SOFTRST),
    .x_vld  (sat_vld),
    .x      (sat_q),
    .y_vld  (res_vld),
    .y      (res)
  );
`else
  assign res     = sat_q;
  assign res_vld = sat_vld;
`endif

  always_ff @(posedge i_EMU_CLK72M) begin
    if (i_EMU_SOFTRST) begin
      out_q <= '0;
      stb_q <= 1'b0;
    end else begin
      stb_q <= res_vld;
      if (res_vld) out_q <= res;
    end
  end

  assign snd.o_SND_L   = out_q;
  assign snd.o_SND_R   = out_q;
  assign snd.o_SND_STB = stb_q;
  assign snd.o_OVERRUN = ovr_q;

endmodule

// File: tb/tb_bubsys_snd_mixer.sv
// Directed self-checking bench for bubsys_snd_mixer; a small filter model tracks
// expected outputs when BUBSYS_SNDMIX_DCBLOCK_EN is defined.
module tb_bubsys_snd_mixer;
  import bubsys_snd_pkg::*;

`ifdef BUBSYS_SNDMIX_DCBLOCK_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 6;
`endif

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;
  int   stb_cnt;
  int   xp;
  int   yp;

  bubsys_snd_mixer_if #(.SMPL_W(16)) snd ();

  bubsys_snd_mixer #(
    .SMPL_W    (16),
    .ACC_W     (20),
    .GAIN_FRAC (5)
  ) dut (
    .i_EMU_CLK72M  (clk),
    .i_EMU_SOFTRST (rst),
    .snd           (snd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (snd.o_SND_STB) stb_cnt <= stb_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int dc_model(input int x);
`ifdef BUBSYS_SNDMIX_DCBLOCK_EN
    int y;
    y = x - xp + yp - (yp >>> 8);
    if (y > 32767) y = 32767;
    if (y < -32768) y = -32768;
    xp = x;
    yp = y;
    return y;
`else
    return x;
`endif
  endfunction

  task automatic set_in(input int k, input int v, input int p1, input int p2, input logic [15:0] vol);
    snd.i_K5289 = 16'(k);
    snd.i_VLM   = 16'(v);
    snd.i_PSG1  = 16'(p1);
    snd.i_PSG2  = 16'(p2);
    snd.i_VOL   = vol;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    xp = 0;
    yp = 0;
  endtask

  // One tick, then wait (bounded) for the strobe; checks latency, both outputs, pulse width.
  task automatic do_mix(input int k, input int v, input int p1, input int p2,
                        input logic [15:0] vol, input int exp_sat, input string tag);
    int lat;
    int e;
    e = dc_model(exp_sat);
    set_in(k, v, p1, p2, vol);
    snd.i_SMPL_CEN = 1'b1;
    @(posedge clk);
    #1 snd.i_SMPL_CEN = 1'b0;
    set_in(0, 0, 0, 0, 16'h0000);
    lat = 0;
    for (int c = 1; c <= 12 && lat == 0; c++) begin
      @(posedge clk);
      #1;
      if (snd.o_SND_STB) lat = c;
    end
    chk({tag, "_lat"}, lat, LAT);
    chk({tag, "_L"}, int'(snd.o_SND_L), e);
    chk({tag, "_R"}, int'(snd.o_SND_R), e);
    @(posedge clk);
    #1 chk({tag, "_stb_1cyc"}, int'(snd.o_SND_STB), 0);
  endtask

  initial begin
    int lat;
    int s0;
    int prev;
    n_assert = 0;
    n_fail   = 0;
    stb_cnt  = 0;
    xp = 0;
    yp = 0;
    snd.i_SMPL_CEN = 1'b0;
    set_in(0, 0, 0, 0, 16'h0000);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_L", int'(snd.o_SND_L), 0);
    chk("rst_R", int'(snd.o_SND_R), 0);
    chk("rst_stb", int'(snd.o_SND_STB), 0);
    chk("rst_ovr", int'(snd.o_OVERRUN), 0);
    chk("rst_fsm", int'(dut.state), int'(ST_IDLE));

    do_mix(1000, 0, 0, 0, 16'h0000, 1000, "t1_unity");
    do_mix(20000, 0, 0, 0, 16'h0007, 32767, "t2_sat_pos");
    do_mix(20000, 0, 0, 0, 16'h000F, 17500, "t2_vol_m1");
    do_mix(-20000, -20000, -20000, -20000, 16'h0000, -32768, "t3_sat_neg");
    do_mix(-20000, -20000, -20000, -20000, 16'h8888, 0, "t3_mute");
    // 100*48/32=150, -64*40/32=-80, 33*16/32=16.5->16
    do_mix(0, 100, -64, 33, 16'hC240, 86, "ch_map");
    do_mix(-1, 0, 0, 0, 16'h000F, -1, "floor_neg");
    do_mix(-32768, 0, 0, 0, 16'h0000, -32768, "min_exact");
    chk("no_ovr_yet", int'(snd.o_OVERRUN), 0);

    // Overrun: second tick (different data) three clocks after the first.
    s0 = stb_cnt;
    prev = dc_model(1234);
    set_in(1234, 0, 0, 0, 16'h0000);
    snd.i_SMPL_CEN = 1'b1;
    @(posedge clk);
    #1 snd.i_SMPL_CEN = 1'b0;
    lat = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      if (c == 2) begin
        set_in(5000, 5000, 0, 0, 16'h0000);
        snd.i_SMPL_CEN = 1'b1;
      end
      if (c == 3) snd.i_SMPL_CEN = 1'b0;
      if (snd.o_SND_STB && lat == 0) lat = c;
    end
    chk("t4_lat", lat, LAT);
    chk("t4_one_stb", stb_cnt - s0, 1);
    chk("t4_first_data_hold", int'(snd.o_SND_L), prev);
    chk("t4_ovr", int'(snd.o_OVERRUN), 1);
    do_mix(300, 0, 0, 0, 16'h0000, 300, "t4_next");
    chk("t4_ovr_sticky", int'(snd.o_OVERRUN), 1);

    // Reset while the FSM is in MAC2.
    set_in(777, 0, 0, 0, 16'h0000);
    snd.i_SMPL_CEN = 1'b1;
    @(posedge clk);
    #1 snd.i_SMPL_CEN = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 chk("t5_in_mac2", int'(dut.state), int'(ST_MAC2));
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    xp = 0;
    yp = 0;
    s0 = stb_cnt;
    repeat (10) @(posedge clk);
    #1;
    chk("t5_no_stb", stb_cnt - s0, 0);
    chk("t5_L0", int'(snd.o_SND_L), 0);
    chk("t5_ovr_clr", int'(snd.o_OVERRUN), 0);
    chk("t5_fsm", int'(dut.state), int'(ST_IDLE));
    do_mix(777, 0, 0, 0, 16'h0000, 777, "t5_after");

    // Reset and tick in the same cycle: the tick is ignored.
    set_in(555, 0, 0, 0, 16'h0000);
    snd.i_SMPL_CEN = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    snd.i_SMPL_CEN = 1'b0;
    rst = 1'b0;
    xp = 0;
    yp = 0;
    s0 = stb_cnt;
    repeat (10) @(posedge clk);
    #1;
    chk("rt_no_stb", stb_cnt - s0, 0);
    chk("rt_L0", int'(snd.o_SND_L), 0);
    chk("rt_fsm", int'(dut.state), int'(ST_IDLE));

`ifdef BUBSYS_SNDMIX_DCBLOCK_EN
    do_reset();
    do_mix(1000, 0, 0, 0, 16'h0000, 1000, "t6_first");
    chk("t6_first_val", int'(snd.o_SND_L), 1000);
    prev = 1000;
    for (int n = 0; n < 4; n++) begin
      do_mix(1000, 0, 0, 0, 16'h0000, 1000, "t6_decay");
      chk("t6_monotonic", int'(int'(snd.o_SND_L) < prev && int'(snd.o_SND_L) > 0), 1);
      prev = int'(snd.o_SND_L);
    end
`else
    do_reset();
    do_mix(1000, 0, 0, 0, 16'h0000, 1000, "t6_nofilter");
    do_mix(1000, 0, 0, 0, 16'h0000, 1000, "t6_nofilter2");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
